agc_accum_bank: RTL and testbench
=================================

# agc_accum_bank

Multi-channel AGC measurement bank, successor to the single-channel square/probit accumulator path. For NCHAN channels it accumulates squared RMS-mux magnitudes and probit threshold counts over a programmable window of 2^WIN_LOG2 clocks. It snapshots all results into a double buffer at window end and streams them out, one channel per beat, over a valid/ready interface. It sits between the per-channel rescale DSPs/LFSR muxes and the shared AGC parameter/measurement logic.

## Interface
Parameters:
- NCHAN, 8, number of channels (1..16)
- NSAMP, 8, threshold bits per channel per clock
- ABITS, 4, magnitude width per channel (unsigned, post-mux)
- SQ_BITS, 25, square accumulator width
- PR_BITS, 21, probit accumulator width
- WIN_LOG2, 17, window length exponent (4..24)
- SQ_OFFSET, 16384, square accumulator reset value

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock; synchronous, active-high
- agc_tick_i  in  1  start (or restart) a measurement window
- abs_i  in  NCHAN*ABITS  per-channel magnitude; channel c at [ABITS*c +: ABITS]
- gt_i  in  NCHAN*NSAMP  per-sample greater-than-threshold flags
- lt_i  in  NCHAN*NSAMP  per-sample less-than-threshold flags
- busy_o  out  1  window running
- done_o  out  1  one-cycle pulse; snapshot taken
- overrun_o  out  1  sticky; a window ended while the readout was incomplete
- m_valid_o  out  1  readout beat valid
- m_ready_i  in  1  readout beat accepted
- m_chan_o  out  $clog2(NCHAN) (min 1)  channel index of beat
- m_last_o  out  1  final channel of snapshot
- m_sq_o  out  SQ_BITS  square sum
- m_gt_o / m_lt_o  out  PR_BITS  probit counts

## Operation
- Per channel, on each window clock: sq += abs*abs (2*ABITS bits, zero-extended); gt += popcount(gt slice); lt += popcount(lt slice).
- All accumulators saturate at all-ones and never wrap. A saturated value is held until the next window start.
- Window start loads sq = SQ_OFFSET and gt = lt = 0.
- Window FSM (agc_pkg::win_state_t): IDLE -> RUN on agc_tick_i. RUN counts N = 2^WIN_LOG2 accumulating clocks, then -> SNAP. SNAP lasts one cycle, then -> IDLE.
  - agc_tick_i in RUN: restart. Accumulators reload, counter clears, no snapshot.
  - agc_tick_i in SNAP: snapshot completes, then -> RUN.
- Snapshot:
  - If the readout is idle, copy all NCHAN results to the hold buffer and start readout at channel 0.
  - If the readout is still in progress, discard the new results, keep the hold buffer unchanged and set overrun_o.
  - done_o pulses in both cases.
- Readout FSM (RD_IDLE, RD_SEND):
  - Present channel k while m_valid_o=1.
  - Advance on m_valid_o && m_ready_i.
  - m_last_o=1 when k=NCHAN-1. Acceptance of the last beat -> RD_IDLE.
  - Data and channel index are stable while valid && !ready.
  - Readout runs concurrently with the next window.
- rst_i:
  - Applies mid-window or mid-readout.
  - Sets both FSMs to idle and clears counter, overrun_o, done_o and m_valid_o.
  - Accumulators take their window-start values.
  - Takes priority over agc_tick_i in the same cycle.

## Timing
- Reset values: busy_o=0, done_o=0, overrun_o=0, m_valid_o=0, m_last_o=0, m_chan_o=0, m_sq_o=SQ_OFFSET, m_gt_o=m_lt_o=0.
- Window cycle numbering: agc_tick_i high at edge t.
  - Inputs are sampled at edges t+1 .. t+N.
  - busy_o is high from after t through after t+N.
  - The snapshot is registered at edge t+N+1.
  - done_o and m_valid_o (channel 0) are high after t+N+1.
- Readout throughput: one beat per clock with m_ready_i held high. NCHAN beats finish by edge t+N+NCHAN+1.
- Back-to-back windows: a tick during SNAP gives its first sample at t'+1, with no gap beyond the SNAP cycle.

## Structure
- Package agc_pkg holds:
  - win_state_t and rd_state_t enums
  - default SQ_OFFSET
  - popcount function
- Sub-module agc_chan_accum holds one channel's three saturating accumulators, with inputs ce, load and abs/gt/lt slices. It is generated NCHAN times.
- The top level holds the window counter, both FSMs, the hold buffer and the output mux.

## Test plan
- WIN_LOG2=4, NCHAN=2, abs={3,5} constant, gt all ones, lt=0, tick once -> done_o at t+17.
  - Beat 0: sq=16384+16*9=16528, gt=128, lt=0.
  - Beat 1: sq=16784, m_last_o=1.
- m_ready_i low for 3 cycles on beat 0 -> values and m_chan_o stable; beat 1 follows the first accepted cycle.
- Second window ends while beat 0 is unaccepted -> overrun_o=1, done_o pulses, and the held beat still shows the first window's values.
- SQ_BITS=10, abs=15 -> sq saturates at 1023 and holds until the next tick; reload gives 16384 mod 2^10 = 0 per the parameter width.
- agc_tick_i at t+8 of a 16-clock window -> no done_o at the original end; done_o at t+8+17; sums cover 16 samples only.
- rst_i at t+10 mid-window and mid-readout -> all outputs at reset values next cycle; a later tick starts a clean window.

Source files
------------

// File: rtl/agc_pkg.sv
// Shared types and helpers for the multi-channel AGC measurement bank.
package agc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SNAP = 2'd2
    } win_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

    localparam int unsigned SQ_OFFSET_DEFAULT = 16384;

    // Slices up to 32 flags wide; narrower slices are zero-extended by the caller.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/agc_chan_accum.sv
// One channel's saturating square-sum and probit-count accumulators.
module agc_chan_accum
    import agc_pkg::*;
#(
    parameter int          NSAMP     = 8,
    parameter int          ABITS     = 4,
    parameter int          SQ_BITS   = 25,
    parameter int          PR_BITS   = 21,
    parameter int unsigned SQ_OFFSET = SQ_OFFSET_DEFAULT
) (
    input  logic               clk_i,
    input  logic               ce,
    input  logic               load,
    input  logic [ABITS-1:0]   abs_mag,
    input  logic [NSAMP-1:0]   gt_flags,
    input  logic [NSAMP-1:0]   lt_flags,
    output logic [SQ_BITS-1:0] sq_sum,
    output logic [PR_BITS-1:0] gt_cnt,
    output logic [PR_BITS-1:0] lt_cnt
);

    // One spare bit above the widest operand catches the carry that means "clamp".
    localparam int SQ_W = ((SQ_BITS > 2 * ABITS) ? SQ_BITS : 2 * ABITS) + 1;
    localparam int PR_W = ((PR_BITS > 6) ? PR_BITS : 6) + 1;
    localparam logic [SQ_W-1:0] SQ_MAX = SQ_W'({SQ_BITS{1'b1}});
    localparam logic [PR_W-1:0] PR_MAX = PR_W'({PR_BITS{1'b1}});

    logic [2*ABITS-1:0] sq_term;
    logic [SQ_W-1:0]    sq_wide;
    logic [PR_W-1:0]    gt_wide;
    logic [PR_W-1:0]    lt_wide;
    logic [SQ_BITS-1:0] sq_next;
    logic [PR_BITS-1:0] gt_next;
    logic [PR_BITS-1:0] lt_next;

    always_comb begin
        sq_term = (2 * ABITS)'(abs_mag) * (2 * ABITS)'(abs_mag);
        sq_wide = SQ_W'(sq_sum) + SQ_W'(sq_term);
        gt_wide = PR_W'(gt_cnt) + PR_W'(popcount(32'(gt_flags)));
        lt_wide = PR_W'(lt_cnt) + PR_W'(popcount(32'(lt_flags)));
        sq_next = (sq_wide > SQ_MAX) ? '1 : sq_wide[SQ_BITS-1:0];
        gt_next = (gt_wide > PR_MAX) ? '1 : gt_wide[PR_BITS-1:0];
        lt_next = (lt_wide > PR_MAX) ? '1 : lt_wide[PR_BITS-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (load) begin
            sq_sum <= SQ_BITS'(SQ_OFFSET);
            gt_cnt <= '0;
            lt_cnt <= '0;
        end else if (ce) begin
            sq_sum <= sq_next;
            gt_cnt <= gt_next;
            lt_cnt <= lt_next;
        end
    end

endmodule

// File: rtl/agc_accum_bank.sv
// NCHAN-channel AGC measurement bank: windowed accumulation, double-buffered
// snapshot and one-channel-per-beat streaming readout.
module agc_accum_bank
    import agc_pkg::*;
#(
    parameter int          NCHAN     = 8,
    parameter int          NSAMP     = 8,
    parameter int          ABITS     = 4,
    parameter int          SQ_BITS   = 25,
    parameter int          PR_BITS   = 21,
    parameter int          WIN_LOG2  = 17,
    parameter int unsigned SQ_OFFSET = SQ_OFFSET_DEFAULT,
    localparam int         CW        = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   agc_tick_i,
    input  logic [NCHAN*ABITS-1:0] abs_i,
    input  logic [NCHAN*NSAMP-1:0] gt_i,
    input  logic [NCHAN*NSAMP-1:0] lt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overrun_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [CW-1:0]          m_chan_o,
    output logic                   m_last_o,
    output logic [SQ_BITS-1:0]     m_sq_o,
    output logic [PR_BITS-1:0]     m_gt_o,
    output logic [PR_BITS-1:0]     m_lt_o,
    output win_state_t             win_state_o,
    output rd_state_t              rd_state_o
);

    win_state_t          win_state;
    rd_state_t           rd_state;
    logic [WIN_LOG2-1:0] win_cnt;
    logic [CW-1:0]       rd_chan;
    logic                last_chan;
    logic                acc_load;
    logic                acc_ce;

    logic [SQ_BITS-1:0] acc_sq  [NCHAN];
    logic [PR_BITS-1:0] acc_gt  [NCHAN];
    logic [PR_BITS-1:0] acc_lt  [NCHAN];
    logic [SQ_BITS-1:0] hold_sq [NCHAN];
    logic [PR_BITS-1:0] hold_gt [NCHAN];
    logic [PR_BITS-1:0] hold_lt [NCHAN];

    // Reset and every tick (including a restart) reload the window-start values.
    assign acc_load = rst_i | agc_tick_i;
    assign acc_ce   = (win_state == RUN);

    for (genvar c = 0; c < NCHAN; c++) begin : g_chan
        agc_chan_accum #(
            .NSAMP     (NSAMP),
            .ABITS     (ABITS),
            .SQ_BITS   (SQ_BITS),
            .PR_BITS   (PR_BITS),
            .SQ_OFFSET (SQ_OFFSET)
        ) u_accum (
            .clk_i    (clk_i),
            .ce       (acc_ce),
            .load     (acc_load),
            .abs_mag  (abs_i[ABITS*c +: ABITS]),
            .gt_flags (gt_i[NSAMP*c +: NSAMP]),
            .lt_flags (lt_i[NSAMP*c +: NSAMP]),
            .sq_sum   (acc_sq[c]),
            .gt_cnt   (acc_gt[c]),
            .lt_cnt   (acc_lt[c])
        );
    end

    // win_cnt wraps to zero on the last accumulating clock, ready for the next window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            win_state <= IDLE;
            win_cnt   <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (win_state)
                IDLE: begin
                    if (agc_tick_i) begin
                        win_state <= RUN;
                        win_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (agc_tick_i) begin
                        win_cnt <= '0;
                    end else begin
                        win_cnt <= win_cnt + WIN_LOG2'(1);
                        if (&win_cnt) win_state <= SNAP;
                    end
                end
                SNAP: begin
                    done_o    <= 1'b1;
                    win_cnt   <= '0;
                    win_state <= agc_tick_i ? RUN : IDLE;
                end
                default: win_state <= IDLE;
            endcase
        end
    end

    // Stream handshake: a beat transfers on a clock where m_valid_o && m_ready_i;
    // once valid is raised, channel and data hold until that transfer happens.
    assign last_chan = (rd_chan == CW'(NCHAN - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_state  <= RD_IDLE;
            rd_chan   <= '0;
            overrun_o <= 1'b0;
            for (int c = 0; c < NCHAN; c++) begin
                hold_sq[c] <= SQ_BITS'(SQ_OFFSET);
                hold_gt[c] <= '0;
                hold_lt[c] <= '0;
            end
        end else begin
            if (rd_state == RD_SEND && m_ready_i) begin
                if (last_chan) begin
                    rd_state <= RD_IDLE;
                    rd_chan  <= '0;
                end else begin
                    rd_chan <= rd_chan + CW'(1);
                end
            end
            // A snapshot arriving while beats are still outstanding is dropped.
            if (win_state == SNAP) begin
                if (rd_state == RD_IDLE) begin
                    rd_state <= RD_SEND;
                    rd_chan  <= '0;
                    for (int c = 0; c < NCHAN; c++) begin
                        hold_sq[c] <= acc_sq[c];
                        hold_gt[c] <= acc_gt[c];
                        hold_lt[c] <= acc_lt[c];
                    end
                end else begin
                    overrun_o <= 1'b1;
                end
            end
        end
    end

    assign busy_o      = (win_state != IDLE);
    assign m_valid_o   = (rd_state == RD_SEND);
    assign m_last_o    = m_valid_o && last_chan;
    assign m_chan_o    = rd_chan;
    assign m_sq_o      = hold_sq[rd_chan];
    assign m_gt_o      = hold_gt[rd_chan];
    assign m_lt_o      = hold_lt[rd_chan];
    assign win_state_o = win_state;
    assign rd_state_o  = rd_state;

endmodule

// File: tb/tb_agc_accum_bank.sv
// Bench for agc_accum_bank: directed window/readout sequences plus randomized
// windows scored against an arithmetic model of the sums.
module tb_agc_accum_bank;
    import agc_pkg::*;

    localparam int NCH = 2;
    localparam int NS  = 8;
    localparam int AB  = 4;
    localparam int WL  = 4;
    localparam int N   = 16;
    localparam int SQA = 25;
    localparam int PRA = 21;
    localparam int SQB = 10;
    localparam int PRB = 7;
    localparam int EW  = 1 + 1 + SQA + 2 * PRA;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              tick  = 1'b0;
    logic              ready = 1'b0;
    logic [NCH*AB-1:0] abs_v = '0;
    logic [NCH*NS-1:0] gt_v  = '0;
    logic [NCH*NS-1:0] lt_v  = '0;

    logic busy_a, done_a, ovr_a, valid_a, last_a;
    logic [0:0] chan_a;
    logic [SQA-1:0] sq_a;
    logic [PRA-1:0] gt_a, lt_a;
    win_state_t ws_a;
    rd_state_t  rs_a;

    logic busy_b, done_b, ovr_b, valid_b, last_b;
    logic [0:0] chan_b;
    logic [SQB-1:0] sq_b;
    logic [PRB-1:0] gt_b, lt_b;
    win_state_t ws_b;
    rd_state_t  rs_b;

    agc_accum_bank #(.NCHAN(NCH), .NSAMP(NS), .ABITS(AB), .SQ_BITS(SQA),
                     .PR_BITS(PRA), .WIN_LOG2(WL)) dut_a (
        .clk_i(clk), .rst_i(rst), .agc_tick_i(tick), .abs_i(abs_v),
        .gt_i(gt_v), .lt_i(lt_v), .busy_o(busy_a), .done_o(done_a),
        .overrun_o(ovr_a), .m_valid_o(valid_a), .m_ready_i(ready),
        .m_chan_o(chan_a), .m_last_o(last_a), .m_sq_o(sq_a), .m_gt_o(gt_a),
        .m_lt_o(lt_a), .win_state_o(ws_a), .rd_state_o(rs_a)
    );

    agc_accum_bank #(.NCHAN(NCH), .NSAMP(NS), .ABITS(AB), .SQ_BITS(SQB),
                     .PR_BITS(PRB), .WIN_LOG2(WL)) dut_b (
        .clk_i(clk), .rst_i(rst), .agc_tick_i(tick), .abs_i(abs_v),
        .gt_i(gt_v), .lt_i(lt_v), .busy_o(busy_b), .done_o(done_b),
        .overrun_o(ovr_b), .m_valid_o(valid_b), .m_ready_i(ready),
        .m_chan_o(chan_b), .m_last_o(last_b), .m_sq_o(sq_b), .m_gt_o(gt_b),
        .m_lt_o(lt_b), .win_state_o(ws_b), .rd_state_o(rs_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_window();
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (N) step();
        step();
    endtask

    // ---------------- scoreboard / model ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_b_q[$];
    longint ms_sq[NCH];
    longint ms_gt[NCH];
    longint ms_lt[NCH];
    int  rd_pend    = 0;
    bit  m_ovr      = 1'b0;
    int  snaps_exp  = 0;
    int  done_seen  = 0;
    bit  mon_en     = 1'b0;

    function automatic logic [EW-1:0] exp_rec(input int c, input int sqw, input int prw);
        longint sq_max, pr_max, sqv, gv, lv;
        sq_max = (longint'(1) << sqw) - 1;
        pr_max = (longint'(1) << prw) - 1;
        sqv = (longint'(16384) % (sq_max + 1)) + ms_sq[c];
        if (sqv > sq_max) sqv = sq_max;
        gv = (ms_gt[c] > pr_max) ? pr_max : ms_gt[c];
        lv = (ms_lt[c] > pr_max) ? pr_max : ms_lt[c];
        return {1'(c), 1'(c == NCH - 1), 25'(sqv), 21'(gv), 21'(lv)};
    endfunction

    // One random clock: t = tick, acc = this edge is a window sample,
    // snap = this edge registers the snapshot of the window just completed.
    task automatic cyc(input bit t, input bit acc, input bit snap, input int rdy_pct);
        bit accept;
        int pend_pre;
        tick  = t;
        ready = ($urandom_range(99) < rdy_pct);
        abs_v = (NCH*AB)'($urandom);
        gt_v  = (NCH*NS)'($urandom);
        lt_v  = (NCH*NS)'($urandom);
        pend_pre = rd_pend;
        accept   = ready && (rd_pend > 0);
        if (snap) begin
            snaps_exp++;
            if (pend_pre == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    exp_q.push_back(exp_rec(c, SQA, PRA));
                    exp_b_q.push_back(exp_rec(c, SQB, PRB));
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (t) begin
            for (int c = 0; c < NCH; c++) begin
                ms_sq[c] = 0; ms_gt[c] = 0; ms_lt[c] = 0;
            end
        end
        if (acc) begin
            for (int c = 0; c < NCH; c++) begin
                ms_sq[c] += longint'(abs_v[AB*c +: AB]) * longint'(abs_v[AB*c +: AB]);
                ms_gt[c] += $countones(gt_v[NS*c +: NS]);
                ms_lt[c] += $countones(lt_v[NS*c +: NS]);
            end
        end
        step();
        if (accept) rd_pend--;
        if (snap && pend_pre == 0) rd_pend = NCH;
        tick = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [EW-1:0] act, e;
            check("rnd valid", valid_a, rd_pend > 0);
            if (done_a) done_seen++;
            if (valid_a && ready) begin
                n_tests++;
                act = {chan_a, last_a, sq_a, gt_a, lt_a};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd beat a: got %h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL rnd beat a: got %h expected %h", act, e);
                    end
                end
            end
            if (valid_b && ready) begin
                n_tests++;
                act = {chan_b, last_b, 25'(sq_b), 21'(gt_b), 21'(lt_b)};
                if (exp_b_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd beat b: got %h expected none", act);
                end else begin
                    e = exp_b_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL rnd beat b: got %h expected %h", act, e);
                    end
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        in_tick;
        logic        in_ready;
        logic        ex_busy;
        logic        ex_done;
        logic        ex_valid;
        logic        chk;
        logic [0:0]  ex_chan;
        logic        ex_last;
        logic [24:0] ex_sq;
        logic [20:0] ex_gt;
        logic [20:0] ex_lt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        for (int i = 0; i < 20; i++) begin
            tbl[i] = '{in_tick: 1'b0, in_ready: 1'b1, ex_busy: (i <= 16),
                       ex_done: (i == 17), ex_valid: (i == 17 || i == 18),
                       chk: 1'b0, ex_chan: 1'b0, ex_last: 1'b0,
                       ex_sq: '0, ex_gt: '0, ex_lt: '0};
        end
        tbl[0].in_tick = 1'b1;
        tbl[17].chk = 1'b1; tbl[17].ex_sq = 25'd16528; tbl[17].ex_gt = 21'd128;
        tbl[18].chk = 1'b1; tbl[18].ex_chan = 1'b1; tbl[18].ex_last = 1'b1;
        tbl[18].ex_sq = 25'd16784; tbl[18].ex_gt = 21'd128;

        // reset state
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst busy", busy_a, 0);
        check("rst done", done_a, 0);
        check("rst ovr", ovr_a, 0);
        check("rst valid", valid_a, 0);
        check("rst last", last_a, 0);
        check("rst chan", chan_a, 0);
        check("rst sq", sq_a, 16384);
        check("rst gt", gt_a, 0);
        check("rst lt", lt_a, 0);
        check("rst sq b", sq_b, 0);

        // basic window, table driven
        abs_v = {4'd5, 4'd3};
        gt_v  = '1;
        lt_v  = '0;
        for (int i = 0; i < 20; i++) begin
            tick  = tbl[i].in_tick;
            ready = tbl[i].in_ready;
            step();
            check($sformatf("t1[%0d] busy", i), busy_a, tbl[i].ex_busy);
            check($sformatf("t1[%0d] done", i), done_a, tbl[i].ex_done);
            check($sformatf("t1[%0d] valid", i), valid_a, tbl[i].ex_valid);
            if (tbl[i].chk) begin
                check($sformatf("t1[%0d] chan", i), chan_a, tbl[i].ex_chan);
                check($sformatf("t1[%0d] last", i), last_a, tbl[i].ex_last);
                check($sformatf("t1[%0d] sq", i), sq_a, tbl[i].ex_sq);
                check($sformatf("t1[%0d] gt", i), gt_a, tbl[i].ex_gt);
                check($sformatf("t1[%0d] lt", i), lt_a, tbl[i].ex_lt);
            end
            if (i == 17) begin
                check("t1 sq b", sq_b, 144);
                check("t1 gt b sat", gt_b, 127);
            end
        end
        tick = 1'b0;

        // stall on beat 0
        abs_v = {4'd7, 4'd2};
        gt_v  = 16'h00FF;
        lt_v  = 16'hFF00;
        ready = 1'b0;
        run_window();
        check("stall done", done_a, 1);
        check("stall valid", valid_a, 1);
        check("stall chan", chan_a, 0);
        check("stall sq", sq_a, 16448);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall[%0d] valid", k), valid_a, 1);
            check($sformatf("stall[%0d] chan", k), chan_a, 0);
            check($sformatf("stall[%0d] sq", k), sq_a, 16448);
            check($sformatf("stall[%0d] gt", k), gt_a, 128);
        end
        ready = 1'b1;
        step();
        check("stall b1 chan", chan_a, 1);
        check("stall b1 last", last_a, 1);
        check("stall b1 sq", sq_a, 17168);
        check("stall b1 lt", lt_a, 128);
        step();
        check("stall end valid", valid_a, 0);

        // saturation on the narrow instance, then reload
        abs_v = {4'd15, 4'd15};
        gt_v  = '1;
        lt_v  = '1;
        run_window();
        check("sat sq b", sq_b, 1023);
        check("sat gt b", gt_b, 127);
        check("sat lt b", lt_b, 127);
        check("sat sq a", sq_a, 19984);
        step();
        step();
        abs_v = '0;
        gt_v  = '0;
        lt_v  = '0;
        run_window();
        check("reload sq b", sq_b, 0);
        check("reload gt b", gt_b, 0);
        check("reload sq a", sq_a, 16384);
        step();
        step();

        // restart at t+8
        abs_v = {4'd1, 4'd1};
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (7) step();
        abs_v = {4'd3, 4'd2};
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("restart[%0d] done", k), done_a, 0);
        end
        step();
        check("restart done", done_a, 1);
        check("restart sq0", sq_a, 16448);
        step();
        check("restart sq1", sq_a, 16528);
        step();

        // overrun: second window ends while beat 0 is held
        abs_v = {4'd1, 4'd1};
        gt_v  = 16'h0101;
        lt_v  = '0;
        ready = 1'b0;
        run_window();
        check("ovr w1 valid", valid_a, 1);
        check("ovr w1 sq", sq_a, 16400);
        check("ovr w1 flag", ovr_a, 0);
        abs_v = {4'd9, 4'd9};
        run_window();
        check("ovr done", done_a, 1);
        check("ovr flag", ovr_a, 1);
        check("ovr valid", valid_a, 1);
        check("ovr chan", chan_a, 0);
        check("ovr sq held", sq_a, 16400);
        check("ovr gt held", gt_a, 16);

        // reset mid-window and mid-readout, with a competing tick
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (9) step();
        rst  = 1'b1;
        tick = 1'b1;
        step();
        rst  = 1'b0;
        tick = 1'b0;
        check("mrst busy", busy_a, 0);
        check("mrst done", done_a, 0);
        check("mrst ovr", ovr_a, 0);
        check("mrst valid", valid_a, 0);
        check("mrst last", last_a, 0);
        check("mrst chan", chan_a, 0);
        check("mrst sq", sq_a, 16384);
        check("mrst gt", gt_a, 0);
        check("mrst lt", lt_a, 0);
        check("mrst sq b", sq_b, 0);
        step();
        check("mrst busy2", busy_a, 0);
        abs_v = {4'd6, 4'd4};
        gt_v  = '0;
        lt_v  = '1;
        ready = 1'b1;
        run_window();
        check("clean sq0", sq_a, 16640);
        check("clean lt0", lt_a, 128);
        check("clean gt0", gt_a, 0);
        check("clean ovr", ovr_a, 0);
        step();
        check("clean sq1", sq_a, 16960);
        step();
        check("clean end", valid_a, 0);

        // randomized windows against the model
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            ms_sq[c] = 0; ms_gt[c] = 0; ms_lt[c] = 0;
        end
        mon_en = 1'b1;
        begin
            bit pend_snap;
            int kind, rp, gap, k;
            pend_snap = 1'b0;
            for (int w = 0; w < 40; w++) begin
                kind = $urandom_range(3);
                case ($urandom_range(3))
                    0: rp = 100;
                    1: rp = 60;
                    2: rp = 30;
                    default: rp = 5;
                endcase
                cyc(1'b1, 1'b0, pend_snap, rp);
                pend_snap = 1'b0;
                if (kind == 0) begin
                    k = $urandom_range(N - 1);
                    repeat (k) cyc(1'b0, 1'b1, 1'b0, rp);
                    cyc(1'b1, 1'b0, 1'b0, rp);
                end
                repeat (N) cyc(1'b0, 1'b1, 1'b0, rp);
                pend_snap = 1'b1;
                if (kind != 1) begin
                    cyc(1'b0, 1'b0, 1'b1, rp);
                    pend_snap = 1'b0;
                    gap = $urandom_range(20);
                    repeat (gap) cyc(1'b0, 1'b0, 1'b0, rp);
                end
            end
            if (pend_snap) cyc(1'b0, 1'b0, 1'b1, 100);
            for (int i = 0; i < 50 && rd_pend > 0; i++) cyc(1'b0, 1'b0, 1'b0, 100);
            cyc(1'b0, 1'b0, 1'b0, 100);
        end
        mon_en = 1'b0;
        check("rnd queue a empty", exp_q.size(), 0);
        check("rnd queue b empty", exp_b_q.size(), 0);
        check("rnd done count", done_seen, snaps_exp);
        check("rnd ovr a", ovr_a, m_ovr);
        check("rnd ovr b", ovr_b, m_ovr);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
